pipeline_sequencer: RTL
=======================

// Module: pipeline_sequencer
// PURPOSE
// - Parametrised stage sequencer for the core pipeline. Gathers per-stage ready bits and issues a
//   one-cycle start pulse to every stage when all are ready and the pipeline is not stalled.
// - Handles jump-induced flushes by holding a configurable set of front stages in reset.
// - Counts committed steps.
// - Sits between the stage modules and the top-level core, driving every stage's start/reset pins.
// PARAMETERS
// - STAGES        5   number of pipeline stages (>=2); bit i = stage i, 0 = fetch
// - FLUSH_STAGES  3   stages 0..FLUSH_STAGES-1 reset on a jump (1..STAGES)
// - FLUSH_CYCLES  2   cycles flush reset is held (>=1)
// - RESET_CYCLES  2   cycles all stage resets are held after global reset release (>=1)
// - COUNT_WIDTH   32  width of step counter
// PORTS
// - clockIn        in   1             single clock, rising edge
// - resetIn        in   1             asynchronous, active-low reset
// - stallIn        in   1             1 = suppress new starts (memory/hazard stall)
// - jumpLatchIn    in   1             1-cycle pulse: taken jump resolved, flush required
// - readyBitsIn    in   STAGES        stage i finished current step
// - startBitsOut   out  STAGES        registered start pulse, all bits equal
// - resetBitsOut   out  STAGES        registered per-stage synchronous reset
// - busyOut        out  1             1 in EXEC/START/FLUSH/RST_HOLD
// - jumpAckOut     out  1             1-cycle pulse on the last flush cycle
// - stepCountOut   out  COUNT_WIDTH   number of start pulses issued since reset
// BEHAVIOUR
// - Reset (resetIn=0, async): state=RST_HOLD, resetBitsOut='1, startBitsOut='0, busyOut=1,
//   jumpAckOut=0, stepCountOut=0, hold counter=RESET_CYCLES-1. Applies immediately mid-operation.
// - allReady = &readyBitsIn. All outputs are registered; decisions use the current-cycle inputs.
// - FSM:
//   RST_HOLD: resetBitsOut='1; counter decrements; at 0 -> WAIT (resetBitsOut='0 from next cycle).
//     jumpLatchIn is ignored here.
//   WAIT: busyOut=0. Priority is jump > stall > start.
//     jumpLatchIn -> FLUSH. Else allReady && !stallIn -> START. Else stay.
//   START: startBitsOut='1 for exactly this cycle; stepCountOut += 1 (wraps mod 2^COUNT_WIDTH).
//     Next state -> EXEC.
//   EXEC: readyBitsIn is ignored in the first EXEC cycle (guard; stages drop ready after start).
//     From the 2nd EXEC cycle, the WAIT decision rules apply, so back-to-back steps are possible:
//     start-to-start minimum is 3 cycles.
//     jumpLatchIn in any EXEC cycle (including guard) -> FLUSH.
//   FLUSH: resetBitsOut[i]=1 for i<FLUSH_STAGES, else 0; startBitsOut='0. Hold lasts FLUSH_CYCLES
//     cycles. jumpAckOut=1 in the final cycle, then -> WAIT.
//     A new jumpLatchIn during FLUSH restarts the hold from full length; jumpAckOut is given only
//     once, at the true end.
//   A jump arriving in a START cycle does not cancel that pulse (already registered).
//     FLUSH follows directly after START, without passing through EXEC.
// - Simultaneous jump + allReady: jump wins, no start, no count increment.
// - stallIn affects only the start decision; it never delays or extends a flush.
// - Stages >= FLUSH_STAGES keep state through a flush; no reset pulse is issued to them.
// - No combinational path from any input to any output.
// CONFIGURATION
// - PIPELINE_SEQ_PERF_EN defined:
//   - Adds stallCountOut [COUNT_WIDTH] (cycles in WAIT/EXEC-after-guard with allReady && stallIn).
//   - Adds flushCountOut [COUNT_WIDTH] (FLUSH entries; restarts excluded).
//   - Both reset to 0 and wrap.
// - PIPELINE_SEQ_PERF_EN undefined: those ports and counters do not exist; all other behaviour
//   is identical.
// TESTING
// - Reset: hold resetIn=0 5 cycles, release -> resetBitsOut=5'b11111 for 2 cycles then 0;
//   no start during hold.
// - Steady run: readyBitsIn=5'b11111 constantly, stallIn=0 -> startBitsOut pulse every 3 cycles;
//   stepCountOut=4 after 4 pulses.
// - Stall: all ready, stallIn=1 for 10 cycles -> no start, stepCountOut unchanged;
//   stallIn drop -> start next cycle.
// - Jump: jumpLatchIn pulse in EXEC -> resetBitsOut=5'b00111 for 2 cycles,
//   jumpAckOut on 2nd, then WAIT. Jump+allReady same cycle -> no start.
// - Re-jump: second jumpLatchIn on 1st FLUSH cycle -> flush reset held 3 cycles total,
//   single jumpAckOut.
// - Async reset mid-FLUSH; plus COUNT_WIDTH=4 wrap after 16 starts -> outputs at reset values at
//   once; counter reads 0 after wrap.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// Pipeline stage sequencer: issues all-stage start pulses, drives per-stage resets for
// power-up hold and jump flushes, and counts steps. Optional perf counters: PIPELINE_SEQ_PERF_EN.
module pipeline_sequencer #(
    parameter int unsigned STAGES       = 5,
    parameter int unsigned FLUSH_STAGES = 3,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned COUNT_WIDTH  = 32
) (
    input  logic                   clockIn,
    input  logic                   resetIn,
    input  logic                   stallIn,
    input  logic                   jumpLatchIn,
    input  logic [STAGES-1:0]      readyBitsIn,
    output logic [STAGES-1:0]      startBitsOut,
    output logic [STAGES-1:0]      resetBitsOut,
    output logic                   busyOut,
    output logic                   jumpAckOut,
`ifdef PIPELINE_SEQ_PERF_EN
    output logic [COUNT_WIDTH-1:0] stallCountOut,
    output logic [COUNT_WIDTH-1:0] flushCountOut,
`endif
    output logic [COUNT_WIDTH-1:0] stepCountOut
);

    localparam int unsigned HoldMax = (RESET_CYCLES > FLUSH_CYCLES) ? RESET_CYCLES : FLUSH_CYCLES;
    localparam int unsigned HoldW   = (HoldMax > 1) ? $clog2(HoldMax) : 1;

    typedef enum logic [2:0] {
        StRstHold,
        StWait,
        StStart,
        StGuard,
        StExec,
        StFlush
    } state_e;

    state_e                 r_state;
    state_e                 w_state_d;
    logic [HoldW-1:0]       r_hold;
    logic [HoldW-1:0]       w_hold_d;
    logic                   w_all_ready;
    logic                   w_flush_entry;
    logic [STAGES-1:0]      w_flush_mask;

    logic [STAGES-1:0]      r_start;
    logic [STAGES-1:0]      r_reset;
    logic                   r_busy;
    logic                   r_ack;
    logic [COUNT_WIDTH-1:0] r_step;
    logic [STAGES-1:0]      w_start_d;
    logic [STAGES-1:0]      w_reset_d;
    logic                   w_busy_d;
    logic                   w_ack_d;
    logic [COUNT_WIDTH-1:0] w_step_d;

    assign w_all_ready = &readyBitsIn;

    always_comb begin
        w_flush_mask = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            w_flush_mask[i] = (i < int'(FLUSH_STAGES));
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_hold_d      = r_hold;
        w_flush_entry = 1'b0;
        case (r_state)
            StRstHold: begin
                // jumpLatchIn deliberately not looked at while stages are held in reset
                if (r_hold == '0) begin
                    w_state_d = StWait;
                end else begin
                    w_hold_d = r_hold - HoldW'(1);
                end
            end
            StWait, StExec: begin
                if (jumpLatchIn) begin
                    w_state_d     = StFlush;
                    w_hold_d      = HoldW'(FLUSH_CYCLES - 1);
                    w_flush_entry = 1'b1;
                end else if (w_all_ready && !stallIn) begin
                    w_state_d = StStart;
                end
            end
            StStart, StGuard: begin
                if (jumpLatchIn) begin
                    w_state_d     = StFlush;
                    w_hold_d      = HoldW'(FLUSH_CYCLES - 1);
                    w_flush_entry = 1'b1;
                end else begin
                    w_state_d = (r_state == StStart) ? StGuard : StExec;
                end
            end
            StFlush: begin
                if (jumpLatchIn) begin
                    w_hold_d = HoldW'(FLUSH_CYCLES - 1);
                end else if (r_hold == '0) begin
                    w_state_d = StWait;
                end else begin
                    w_hold_d = r_hold - HoldW'(1);
                end
            end
            default: begin
                w_state_d = StRstHold;
                w_hold_d  = HoldW'(RESET_CYCLES - 1);
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_comb begin
        w_start_d = (w_state_d == StStart) ? '1 : '0;
        w_reset_d = '0;
        if (w_state_d == StRstHold) begin
            w_reset_d = '1;
        end else if (w_state_d == StFlush) begin
            w_reset_d = w_flush_mask;
        end
        w_busy_d = (w_state_d != StWait);
        w_ack_d  = (w_state_d == StFlush) && (w_hold_d == '0);
        w_step_d = (w_state_d == StStart) ? r_step + COUNT_WIDTH'(1) : r_step;
    end

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            r_state <= StRstHold;
            r_hold  <= HoldW'(RESET_CYCLES - 1);
            r_start <= '0;
            r_reset <= '1;
            r_busy  <= 1'b1;
            r_ack   <= 1'b0;
            r_step  <= '0;
        end else begin
            r_state <= w_state_d;
            r_hold  <= w_hold_d;
            r_start <= w_start_d;
            r_reset <= w_reset_d;
            r_busy  <= w_busy_d;
            r_ack   <= w_ack_d;
            r_step  <= w_step_d;
        end
    end

    assign startBitsOut = r_start;
    assign resetBitsOut = r_reset;
    assign busyOut      = r_busy;
    assign jumpAckOut   = r_ack;
    assign stepCountOut = r_step;

`ifdef PIPELINE_SEQ_PERF_EN
    logic [COUNT_WIDTH-1:0] r_stall_cnt;
    logic [COUNT_WIDTH-1:0] r_flush_cnt;
    logic                   w_stall_hit;

    // Guard cycle excluded: readiness is not considered there
    assign w_stall_hit = ((r_state == StWait) || (r_state == StExec)) && w_all_ready && stallIn;

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_hit) begin
                r_stall_cnt <= r_stall_cnt + COUNT_WIDTH'(1);
            end
            if (w_flush_entry) begin
                r_flush_cnt <= r_flush_cnt + COUNT_WIDTH'(1);
            end
        end
    end

    assign stallCountOut = r_stall_cnt;
    assign flushCountOut = r_flush_cnt;
`endif

endmodule
